parking_duration_tracker: RTL and testbench

Multi-slot occupancy timer for the parking-lot controller: keeps a free-running time base, timestamps an entry event per slot, and on exit reports the elapsed duration `now − entry_time` modulo 2^WIDTH. It is the parametrised, sequential successor to the single 8-bit exit-minus-entry subtractor. It adds per-slot storage, occupancy tracking, wrap-around detection, optional saturation and error flags. It sits between the gate sensors and the billing logic.

---
 rtl/parking_duration_tracker.sv | 214 +++++++++++++++++++++
 tb/tb_parking_duration_tracker.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/parking_duration_tracker.sv
`default_nettype none
// ============================================================================
// Module      : parking_duration_tracker
// Description : Multi-slot occupancy timer. Keeps a free-running time base,
//               timestamps an entry per slot, and reports the elapsed
//               duration (now - entry time, modulo 2^WIDTH) on exit. Includes
//               wrap-around detection, optional saturation and error pulses.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk            in   1      rising-edge clock
//   rst_n          in   1      asynchronous active-low reset
//   tick_i         in   1      advance time base by one
//   entry_valid_i  in   1      car enters entry_slot_i this cycle
//   entry_slot_i   in   SW     entry slot index
//   exit_valid_i   in   1      car leaves exit_slot_i this cycle
//   exit_slot_i    in   SW     exit slot index
//   now_o          out  WIDTH  current time base
//   occupied_o     out  SLOTS  per-slot occupancy flags
//   full_o         out  1      all slots occupied
//   empty_o        out  1      no slot occupied
//   dur_valid_o    out  1      one-cycle pulse, duration result available
//   dur_slot_o     out  SW     slot the result belongs to
//   dur_value_o    out  WIDTH  elapsed ticks
//   dur_sat_o      out  1      elapsed time reached 2^WIDTH ticks
//   err_entry_o    out  1      pulse: entry to an occupied slot
//   err_exit_o     out  1      pulse: exit from an empty slot
// ============================================================================
module parking_duration_tracker #(
  parameter int WIDTH    = 8,
  parameter int SLOTS    = 4,
  parameter int SATURATE = 1,
  localparam int SW      = $clog2(SLOTS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_i,
  input  logic             entry_valid_i,
  input  logic [SW-1:0]    entry_slot_i,
  input  logic             exit_valid_i,
  input  logic [SW-1:0]    exit_slot_i,
  output logic [WIDTH-1:0] now_o,
  output logic [SLOTS-1:0] occupied_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             dur_valid_o,
  output logic [SW-1:0]    dur_slot_o,
  output logic [WIDTH-1:0] dur_value_o,
  output logic             dur_sat_o,
  output logic             err_entry_o,
  output logic             err_exit_o
);

  localparam logic [SW:0] c_SLOTS = (SW+1)'(SLOTS);

  // Time base
  logic [WIDTH-1:0] now_q, now_d;

  // Per-slot state gathered into vectors for the shared exit/entry muxes
  logic [SLOTS-1:0] w_occ_q;
  logic [SLOTS-1:0] w_occ_d;
  logic [SLOTS-1:0] w_wrap_q;
  logic [WIDTH-1:0] w_ts_q [SLOTS];

  // Registered outputs
  logic             full_q, empty_q;
  logic             dur_valid_q;
  logic [SW-1:0]    dur_slot_q;
  logic [WIDTH-1:0] dur_value_q;
  logic             dur_sat_q;
  logic             err_entry_q, err_exit_q;

  // Event qualification: indices beyond the last slot are silently dropped
  logic w_entry_ok, w_exit_ok;
  assign w_entry_ok = entry_valid_i && ({1'b0, entry_slot_i} < c_SLOTS);
  assign w_exit_ok  = exit_valid_i  && ({1'b0, exit_slot_i}  < c_SLOTS);

  assign now_d = now_q + {{(WIDTH-1){1'b0}}, tick_i};

  // Select the addressed slot's state for exit and entry
  logic [WIDTH-1:0] w_x_ts;
  logic             w_x_wrap;
  logic             w_x_occ;
  logic             w_e_occ;

  always_comb begin
    w_x_ts   = '0;
    w_x_wrap = 1'b0;
    w_x_occ  = 1'b0;
    w_e_occ  = 1'b0;
    for (int s = 0; s < SLOTS; s++) begin
      if (exit_slot_i == SW'(s)) begin
        w_x_ts   = w_ts_q[s];
        w_x_wrap = w_wrap_q[s];
        w_x_occ  = w_occ_q[s];
      end
      if (entry_slot_i == SW'(s)) begin
        w_e_occ = w_occ_q[s];
      end
    end
  end

  logic             w_exit_do;
  logic             w_same_slot;
  logic             w_err_entry;
  logic             w_err_exit;
  logic [WIDTH-1:0] w_elapsed;
  logic [WIDTH-1:0] w_dur_value;

  assign w_exit_do   = w_exit_ok && w_x_occ;
  assign w_err_exit  = w_exit_ok && !w_x_occ;
  assign w_same_slot = w_exit_ok && (entry_slot_i == exit_slot_i);
  // An occupied slot that is also being exited this cycle is a turnover,
  // not a double entry.
  assign w_err_entry = w_entry_ok && w_e_occ && !w_same_slot;
  assign w_elapsed   = now_q - w_x_ts;
  assign w_dur_value = (w_x_wrap && (SATURATE != 0)) ? {WIDTH{1'b1}} : w_elapsed;

  // --------------------------------------------------------------------------
  // Per-slot storage
  // --------------------------------------------------------------------------
  for (genvar s = 0; s < SLOTS; s++) begin : g_slot
    logic             occ_q, occ_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] ts_q, ts_d;
    logic             w_entry_hit, w_exit_hit, w_exit_do_s, w_entry_acc;

    assign w_entry_hit = w_entry_ok && (entry_slot_i == SW'(s));
    assign w_exit_hit  = w_exit_ok  && (exit_slot_i  == SW'(s));
    assign w_exit_do_s = w_exit_hit && occ_q;
    // Entry lands if the slot is free, or is being vacated in the same cycle
    assign w_entry_acc = w_entry_hit && (!occ_q || w_exit_do_s);

    always_comb begin
      occ_d  = occ_q;
      wrap_d = wrap_q;
      ts_d   = ts_q;
      if (w_entry_acc) begin
        occ_d  = 1'b1;
        wrap_d = 1'b0;
        ts_d   = now_q;
      end else begin
        if (w_exit_do_s) begin
          occ_d = 1'b0;
        end
        // The tick that brings the time base back round to the entry stamp
        // marks a full 2^WIDTH-tick stay; sticky until the next entry.
        if (tick_i && occ_q && (now_d == ts_q)) begin
          wrap_d = 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        occ_q  <= 1'b0;
        wrap_q <= 1'b0;
        ts_q   <= '0;
      end else begin
        occ_q  <= occ_d;
        wrap_q <= wrap_d;
        ts_q   <= ts_d;
      end
    end

    assign w_occ_q[s]  = occ_q;
    assign w_occ_d[s]  = occ_d;
    assign w_wrap_q[s] = wrap_q;
    assign w_ts_q[s]   = ts_q;
  end

  // --------------------------------------------------------------------------
  // Time base, status and result registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      now_q       <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      dur_valid_q <= 1'b0;
      dur_slot_q  <= '0;
      dur_value_q <= '0;
      dur_sat_q   <= 1'b0;
      err_entry_q <= 1'b0;
      err_exit_q  <= 1'b0;
    end else begin
      now_q       <= now_d;
      full_q      <= &w_occ_d;
      empty_q     <= ~|w_occ_d;
      dur_valid_q <= w_exit_do;
      err_entry_q <= w_err_entry;
      err_exit_q  <= w_err_exit;
      // Result fields hold their last value between pulses
      if (w_exit_do) begin
        dur_slot_q  <= exit_slot_i;
        dur_value_q <= w_dur_value;
        dur_sat_q   <= w_x_wrap;
      end
    end
  end

  assign now_o       = now_q;
  assign occupied_o  = w_occ_q;
  assign full_o      = full_q;
  assign empty_o     = empty_q;
  assign dur_valid_o = dur_valid_q;
  assign dur_slot_o  = dur_slot_q;
  assign dur_value_o = dur_value_q;
  assign dur_sat_o   = dur_sat_q;
  assign err_entry_o = err_entry_q;
  assign err_exit_o  = err_exit_q;

endmodule
`default_nettype wire

// File: tb/tb_parking_duration_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_parking_duration_tracker
// Description : Self-checking bench. Two instances (saturating and modular)
//               receive identical stimulus; a reference model tracks absolute
//               (unbounded) time and entry times per slot.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_parking_duration_tracker;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic       entry_valid;
  logic [1:0] entry_slot;
  logic       exit_valid;
  logic [1:0] exit_slot;

  logic [7:0] a_now, b_now;
  logic [3:0] a_occ, b_occ;
  logic       a_full, b_full, a_empty, b_empty;
  logic       a_dv, b_dv;
  logic [1:0] a_dslot, b_dslot;
  logic [7:0] a_dval, b_dval;
  logic       a_dsat, b_dsat;
  logic       a_ee, b_ee, a_ex, b_ex;

  parking_duration_tracker #(.WIDTH(8), .SLOTS(4), .SATURATE(1)) u_dut_sat (
    .clk(clk), .rst_n(rst_n), .tick_i(tick),
    .entry_valid_i(entry_valid), .entry_slot_i(entry_slot),
    .exit_valid_i(exit_valid), .exit_slot_i(exit_slot),
    .now_o(a_now), .occupied_o(a_occ), .full_o(a_full), .empty_o(a_empty),
    .dur_valid_o(a_dv), .dur_slot_o(a_dslot), .dur_value_o(a_dval),
    .dur_sat_o(a_dsat), .err_entry_o(a_ee), .err_exit_o(a_ex)
  );

  parking_duration_tracker #(.WIDTH(8), .SLOTS(4), .SATURATE(0)) u_dut_mod (
    .clk(clk), .rst_n(rst_n), .tick_i(tick),
    .entry_valid_i(entry_valid), .entry_slot_i(entry_slot),
    .exit_valid_i(exit_valid), .exit_slot_i(exit_slot),
    .now_o(b_now), .occupied_o(b_occ), .full_o(b_full), .empty_o(b_empty),
    .dur_valid_o(b_dv), .dur_slot_o(b_dslot), .dur_value_o(b_dval),
    .dur_sat_o(b_dsat), .err_entry_o(b_ee), .err_exit_o(b_ex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: absolute time, never wraps
  longint abs_t;
  int     occ_m [4];
  longint ent_m [4];
  int     m_dv, m_ee, m_ex, m_dslot, m_dsat;
  longint m_dval_sat, m_dval_mod;

  task automatic chk(input string tag, input longint obs, input longint exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    abs_t = 0;
    for (int i = 0; i < 4; i++) begin
      occ_m[i] = 0;
      ent_m[i] = 0;
    end
    m_dv = 0; m_ee = 0; m_ex = 0; m_dslot = 0; m_dsat = 0;
    m_dval_sat = 0; m_dval_mod = 0;
  endtask

  // Exit is handled before entry, which yields turnover on the same slot
  task automatic model_event(input logic t, input logic ev, input int es,
                             input logic xv, input int xs);
    longint el;
    m_dv = 0; m_ee = 0; m_ex = 0;
    if (xv) begin
      if (occ_m[xs] != 0) begin
        el         = abs_t - ent_m[xs];
        m_dv       = 1;
        m_dslot    = xs;
        m_dsat     = (el >= 256) ? 1 : 0;
        m_dval_mod = el % 256;
        m_dval_sat = (el >= 256) ? 255 : el % 256;
        occ_m[xs]  = 0;
      end else begin
        m_ex = 1;
      end
    end
    if (ev) begin
      if (occ_m[es] != 0) begin
        m_ee = 1;
      end else begin
        occ_m[es] = 1;
        ent_m[es] = abs_t;
      end
    end
    if (t) abs_t++;
  endtask

  task automatic check_all();
    int occv;
    occv = 0;
    for (int i = 0; i < 4; i++) occv |= occ_m[i] << i;
    chk("now_sat",       a_now,   abs_t % 256);
    chk("now_mod",       b_now,   abs_t % 256);
    chk("occupied_sat",  a_occ,   occv);
    chk("occupied_mod",  b_occ,   occv);
    chk("full",          a_full,  (occv == 15) ? 1 : 0);
    chk("empty",         a_empty, (occv == 0) ? 1 : 0);
    chk("dur_valid_sat", a_dv,    m_dv);
    chk("dur_valid_mod", b_dv,    m_dv);
    chk("dur_slot",      a_dslot, m_dslot);
    chk("dur_value_sat", a_dval,  m_dval_sat);
    chk("dur_value_mod", b_dval,  m_dval_mod);
    chk("dur_sat_sat",   a_dsat,  m_dsat);
    chk("dur_sat_mod",   b_dsat,  m_dsat);
    chk("err_entry",     a_ee,    m_ee);
    chk("err_exit",      a_ex,    m_ex);
    chk("err_entry_mod", b_ee,    m_ee);
    chk("err_exit_mod",  b_ex,    m_ex);
  endtask

  // Called 1 time unit after a rising edge; drives, clocks, then checks
  task automatic step(input logic t, input logic ev, input int es,
                      input logic xv, input int xs);
    tick        = t;
    entry_valid = ev;
    entry_slot  = 2'(es);
    exit_valid  = xv;
    exit_slot   = 2'(xs);
    @(posedge clk);
    model_event(t, ev, es, xv, xs);
    #1;
    check_all();
  endtask

  task automatic ticks(input int n);
    repeat (n) step(1'b1, 1'b0, 0, 1'b0, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick = 1'b0; entry_valid = 1'b0; exit_valid = 1'b0;
    entry_slot = 2'd0; exit_slot = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_all();
    rst_n = 1'b1;
  endtask

  initial begin
    #1;
    do_reset();

    // Basic duration
    ticks(10);
    step(1'b0, 1'b1, 2, 1'b0, 0);
    ticks(25);
    step(1'b0, 1'b0, 0, 1'b1, 2);
    chk("basic_dur_valid", a_dv, 1);
    chk("basic_dur_slot", a_dslot, 2);
    chk("basic_dur_value", a_dval, 25);
    chk("basic_dur_sat", a_dsat, 0);
    chk("basic_occupied", a_occ, 0);

    // Modular wrap of the time base (now 35 -> 250)
    ticks(215);
    chk("wrap_now_start", a_now, 250);
    step(1'b0, 1'b1, 0, 1'b0, 0);
    ticks(10);
    chk("wrap_now_end", a_now, 4);
    step(1'b0, 1'b0, 0, 1'b1, 0);
    chk("wrap_dur_value", a_dval, 10);
    chk("wrap_dur_sat", a_dsat, 0);

    // Long stay of 259 ticks
    ticks(1);
    step(1'b0, 1'b1, 1, 1'b0, 0);
    ticks(259);
    step(1'b0, 1'b0, 0, 1'b1, 1);
    chk("long_value_sat", a_dval, 255);
    chk("long_sat_sat", a_dsat, 1);
    chk("long_value_mod", b_dval, 3);
    chk("long_sat_mod", b_dsat, 1);

    // Errors
    step(1'b0, 1'b0, 0, 1'b1, 3);
    chk("err_exit_pulse", a_ex, 1);
    chk("err_exit_no_dv", a_dv, 0);
    ticks(255);
    chk("err_now7", a_now, 7);
    step(1'b0, 1'b1, 1, 1'b0, 0);
    ticks(2);
    step(1'b0, 1'b1, 1, 1'b0, 0);
    chk("err_entry_pulse", a_ee, 1);
    ticks(3);
    step(1'b0, 1'b0, 0, 1'b1, 1);
    chk("err_entry_value", a_dval, 5);

    // Fill all slots, then same-cycle turnover on slot 0 with tick
    ticks(18);
    step(1'b0, 1'b1, 0, 1'b0, 0);
    step(1'b0, 1'b1, 1, 1'b0, 0);
    step(1'b0, 1'b1, 2, 1'b0, 0);
    step(1'b0, 1'b1, 3, 1'b0, 0);
    chk("fill_full", a_full, 1);
    ticks(10);
    chk("turn_now40", a_now, 40);
    step(1'b1, 1'b1, 0, 1'b1, 0);
    chk("turn_value", a_dval, 10);
    chk("turn_full", a_full, 1);
    chk("turn_occupied", a_occ, 15);
    chk("turn_no_err_entry", a_ee, 0);
    ticks(2);
    step(1'b0, 1'b0, 0, 1'b1, 0);
    chk("turn_new_ts", a_dval, 3);

    // Random traffic: short stays, then long stays
    for (int n = 0; n < 2500; n++)
      step($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 3, int'($urandom_range(0, 3)),
           $urandom_range(0, 9) < 2, int'($urandom_range(0, 3)));
    for (int n = 0; n < 2500; n++)
      step($urandom_range(0, 9) < 9, $urandom_range(0, 9) < 2, int'($urandom_range(0, 3)),
           $urandom_range(0, 49) == 0, int'($urandom_range(0, 3)));

    // A pending pulse is cancelled as soon as reset asserts
    do_reset();
    step(1'b0, 1'b1, 0, 1'b0, 0);
    step(1'b1, 1'b1, 1, 1'b0, 0);
    ticks(3);
    step(1'b0, 1'b0, 0, 1'b1, 1);
    chk("pre_reset_dv", a_dv, 1);
    rst_n = 1'b0;
    #1;
    chk("async_cancel_dv", a_dv, 0);
    chk("async_cancel_now", a_now, 0);
    #4;
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;

    // Reset asserted during an exit cycle
    step(1'b0, 1'b1, 0, 1'b0, 0);
    step(1'b1, 1'b1, 1, 1'b0, 0);
    ticks(2);
    tick = 1'b0; entry_valid = 1'b0; exit_valid = 1'b1; exit_slot = 2'd0;
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    chk("rst_exit_no_dv", a_dv, 0);
    chk("rst_now", a_now, 0);
    chk("rst_occupied", a_occ, 0);
    chk("rst_empty", a_empty, 1);
    check_all();
    #3;
    rst_n = 1'b1;
    exit_valid = 1'b0;
    @(posedge clk);
    #1;
    check_all();
    ticks(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
